// File: rtl/memoria_dados_param.sv
// -----------------------------------------------------------------------------
// memoria_dados_param
//
// Parametrised single-port data memory for the RISC-V core. It sits between the
// ALU address output and the write-back mux. Stores are clocked and loads are
// registered with one cycle of latency. After reset the memory clears itself,
// one word per clock. Requests are accepted only once the clear is done.
//
// Parameters
//   DEPTH_WORDS  number of 32-bit words. Must be a power of two, minimum 4.
//   ADDR_W       width of the byte address input.
//   IDX_W        derived word-index width, $clog2(DEPTH_WORDS).
//
// Ports
//   clk       in   rising-edge clock
//   rst_n     in   asynchronous active-low reset; restarts the clear sequence
//   rs        in   byte address; wraps modulo 4*DEPTH_WORDS
//   wd        in   store data, right-aligned
//   wr        in   store request
//   re        in   load request (ignored when wr is high)
//   funct3    in   RISC-V access size and sign encoding
//   rd        out  registered load result; holds between loads
//   rd_valid  out  one-cycle pulse: rd was updated this cycle
//   ready     out  high once the clear sequence has finished
//   err       out  one-cycle pulse: the previous request was rejected
// -----------------------------------------------------------------------------
module memoria_dados_param #(
  parameter int DEPTH_WORDS = 1024,
  parameter int ADDR_W      = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] rs,
  input  logic [31:0]       wd,
  input  logic              wr,
  input  logic              re,
  input  logic [2:0]        funct3,
  output logic [31:0]       rd,
  output logic              rd_valid,
  output logic              ready,
  output logic              err
);

  localparam int IDX_W = $clog2(DEPTH_WORDS);

  typedef enum logic [0:0] {
    ST_INIT = 1'b0,
    ST_IDLE = 1'b1
  } state_t;

  // ---------------------------------------------------------------------------
  // Access helpers
  // ---------------------------------------------------------------------------

  // Report whether a request with this funct3 and byte offset is legal.
  // Stores accept only sb/sh/sw. Loads also accept the unsigned variants.
  function automatic logic access_ok(input logic [2:0] f3,
                                     input logic [1:0] off,
                                     input logic       is_store);
    logic ok;
    case (f3)
      3'b000:  ok = 1'b1;
      3'b001:  ok = (off[0] == 1'b0);
      3'b010:  ok = (off == 2'b00);
      3'b100:  ok = ~is_store;
      3'b101:  ok = ~is_store & (off[0] == 1'b0);
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

  // Return the byte-lane enables for a store of this size at this offset.
  function automatic logic [3:0] store_lanes(input logic [2:0] f3,
                                             input logic [1:0] off);
    logic [3:0] be;
    case (f3)
      3'b000:  be = 4'b0001 << off;
      3'b001:  be = off[1] ? 4'b1100 : 4'b0011;
      3'b010:  be = 4'b1111;
      default: be = 4'b0000;
    endcase
    return be;
  endfunction

  // Replicate right-aligned store data across the lanes.
  // The lane enables then pick the lanes that are actually written.
  function automatic logic [31:0] store_data(input logic [2:0]  f3,
                                             input logic [31:0] data);
    logic [31:0] w;
    case (f3)
      3'b000:  w = {4{data[7:0]}};
      3'b001:  w = {2{data[15:0]}};
      default: w = data;
    endcase
    return w;
  endfunction

  // Extract the addressed byte or halfword and sign-/zero-extend it.
  function automatic logic [31:0] load_extract(input logic [31:0] word,
                                               input logic [2:0]  f3,
                                               input logic [1:0]  off);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] v;
    case (off)
      2'b00:   b = word[7:0];
      2'b01:   b = word[15:8];
      2'b10:   b = word[23:16];
      2'b11:   b = word[31:24];
      default: b = 8'h00;
    endcase
    h = off[1] ? word[31:16] : word[15:0];
    case (f3)
      3'b000:  v = {{24{b[7]}}, b};
      3'b100:  v = {24'h000000, b};
      3'b001:  v = {{16{h[15]}}, h};
      3'b101:  v = {16'h0000, h};
      3'b010:  v = word;
      default: v = 32'h0000_0000;
    endcase
    return v;
  endfunction

  // ---------------------------------------------------------------------------
  // Storage and state
  // ---------------------------------------------------------------------------
  logic [31:0]      mem_r [DEPTH_WORDS];
  state_t           state_r;
  state_t           state_nxt_s;
  logic [IDX_W-1:0] clr_cnt_r;
  logic [IDX_W-1:0] clr_cnt_nxt_s;
  logic             ready_r;
  logic             ready_nxt_s;
  logic [31:0]      rd_r;
  logic [31:0]      rd_nxt_s;
  logic             rd_valid_r;
  logic             rd_valid_nxt_s;
  logic             err_r;
  logic             err_nxt_s;

  logic [IDX_W-1:0] idx_s;
  logic [1:0]       off_s;
  logic [31:0]      rd_word_s;

  logic             mem_we_s;
  logic [IDX_W-1:0] mem_idx_s;
  logic [3:0]       mem_be_s;
  logic [31:0]      mem_wdata_s;

  // Upper address bits are deliberately ignored so that the address wraps.
  generate
    if (ADDR_W > IDX_W + 2) begin : g_addr_hi
      logic unused_addr_hi_s;
      assign unused_addr_hi_s = ^rs[ADDR_W-1:IDX_W+2];
    end
  endgenerate

  assign idx_s     = rs[IDX_W+1:2];
  assign off_s     = rs[1:0];
  assign rd_word_s = mem_r[idx_s];

  // Decide the next state, any memory write and the next output values.
  always_comb begin
    state_nxt_s    = state_r;
    clr_cnt_nxt_s  = clr_cnt_r;
    ready_nxt_s    = ready_r;
    rd_nxt_s       = rd_r;
    rd_valid_nxt_s = 1'b0;
    err_nxt_s      = 1'b0;
    mem_we_s       = 1'b0;
    mem_idx_s      = idx_s;
    mem_be_s       = 4'b0000;
    mem_wdata_s    = 32'h0000_0000;

    case (state_r)
      ST_INIT: begin
        // Clear one word per edge. Core requests are ignored here.
        mem_we_s      = 1'b1;
        mem_idx_s     = clr_cnt_r;
        mem_be_s      = 4'b1111;
        mem_wdata_s   = 32'h0000_0000;
        clr_cnt_nxt_s = clr_cnt_r + IDX_W'(1);
        if (clr_cnt_r == IDX_W'(DEPTH_WORDS - 1)) begin
          state_nxt_s = ST_IDLE;
          ready_nxt_s = 1'b1;
        end else begin
          state_nxt_s = ST_INIT;
        end
      end

      ST_IDLE: begin
        if (wr) begin
          // A store wins over a simultaneous load. The load is dropped.
          if (access_ok(funct3, off_s, 1'b1)) begin
            mem_we_s    = 1'b1;
            mem_be_s    = store_lanes(funct3, off_s);
            mem_wdata_s = store_data(funct3, wd);
          end else begin
            err_nxt_s = 1'b1;
          end
        end else if (re) begin
          if (access_ok(funct3, off_s, 1'b0)) begin
            rd_nxt_s       = load_extract(rd_word_s, funct3, off_s);
            rd_valid_nxt_s = 1'b1;
          end else begin
            err_nxt_s = 1'b1;
          end
        end else begin
          rd_valid_nxt_s = 1'b0;
        end
      end

      default: begin
        state_nxt_s   = ST_INIT;
        clr_cnt_nxt_s = '0;
        ready_nxt_s   = 1'b0;
      end
    endcase
  end

  // Control and output registers; asynchronous reset restarts the clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= ST_INIT;
      clr_cnt_r  <= '0;
      ready_r    <= 1'b0;
      rd_r       <= 32'h0000_0000;
      rd_valid_r <= 1'b0;
      err_r      <= 1'b0;
    end else begin
      state_r    <= state_nxt_s;
      clr_cnt_r  <= clr_cnt_nxt_s;
      ready_r    <= ready_nxt_s;
      rd_r       <= rd_nxt_s;
      rd_valid_r <= rd_valid_nxt_s;
      err_r      <= err_nxt_s;
    end
  end

  // Byte-lane write port.
  // The array has no reset; the clear sequence gives it a known value.
  always_ff @(posedge clk) begin
    for (int lane = 0; lane < 4; lane++) begin
      if (mem_we_s && mem_be_s[lane]) begin
        mem_r[mem_idx_s][8*lane +: 8] <= mem_wdata_s[8*lane +: 8];
      end
    end
  end

  assign rd       = rd_r;
  assign rd_valid = rd_valid_r;
  assign ready    = ready_r;
  assign err      = err_r;

endmodule

// File: tb/tb_memoria_dados_param.sv
// -----------------------------------------------------------------------------
// Self-checking bench for memoria_dados_param with DEPTH_WORDS=16.
// Phases:
//   - the clear sequence after reset;
//   - a directed vector table with hand-derived expected values;
//   - random traffic compared against a byte-array reference model;
//   - asynchronous reset during a load and during the clear.
// -----------------------------------------------------------------------------
module tb_memoria_dados_param;

  localparam int DEPTH = 16;
  localparam int BYTES = 4 * DEPTH;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] rs = 32'h0;
  logic [31:0] wd = 32'h0;
  logic        wr = 1'b0;
  logic        re = 1'b0;
  logic [2:0]  funct3 = 3'b000;
  logic [31:0] rd;
  logic        rd_valid;
  logic        ready;
  logic        err;

  always #5 clk = ~clk;

  memoria_dados_param #(.DEPTH_WORDS(DEPTH), .ADDR_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .rs(rs), .wd(wd), .wr(wr), .re(re),
    .funct3(funct3), .rd(rd), .rd_valid(rd_valid), .ready(ready), .err(err)
  );

  int n_pass = 0;
  int n_total = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
  endtask

  // Reference model: a flat byte array plus the last load result.
  logic [7:0]  model_bytes [BYTES];
  logic [31:0] model_rd;

  task automatic model_reset();
    for (int i = 0; i < BYTES; i++) model_bytes[i] = 8'h00;
    model_rd = 32'h0;
  endtask

  task automatic model_apply(input logic w, input logic r, input logic [2:0] f,
                             input logic [31:0] a, input logic [31:0] d,
                             output logic ev, output logic ee);
    int size;
    int base;
    logic legal;
    longint v;
    ev = 1'b0;
    ee = 1'b0;
    case (f[1:0])
      2'd0: size = 1;
      2'd1: size = 2;
      2'd2: size = 4;
      default: size = 0;
    endcase
    base = int'(a % 32'd64);
    if (w) begin
      legal = (size != 0) && (f[2] == 1'b0) && (base % size == 0);
      if (legal) begin
        for (int i = 0; i < size; i++) model_bytes[base + i] = d[8*i +: 8];
      end
      ee = ~legal;
    end else if (r) begin
      legal = (size != 0) && !(f[2] && size == 4) && (base % size == 0);
      if (legal) begin
        v = 0;
        for (int i = 0; i < size; i++) v = v + (longint'(model_bytes[base + i]) << (8 * i));
        if (!f[2] && size < 4 && v >= (longint'(1) << (8 * size - 1)))
          v = v - (longint'(1) << (8 * size));
        model_rd = v[31:0];
        ev = 1'b1;
      end else begin
        ee = 1'b1;
      end
    end
  endtask

  // Apply one request for one edge and update the model.
  // When chk is set, compare rd, rd_valid and err against the model.
  task automatic op(input logic w, input logic r, input logic [2:0] f,
                    input logic [31:0] a, input logic [31:0] d, input logic chk);
    logic ev, ee;
    wr = w; re = r; funct3 = f; rs = a; wd = d;
    model_apply(w, r, f, a, d, ev, ee);
    @(posedge clk); #1;
    if (chk) begin
      check("model_rd", rd, model_rd);
      check("model_rd_valid", {31'b0, rd_valid}, {31'b0, ev});
      check("model_err", {31'b0, err}, {31'b0, ee});
    end
    wr = 1'b0; re = 1'b0;
  endtask

  typedef struct {
    logic        w;
    logic        r;
    logic [2:0]  f;
    logic [31:0] a;
    logic [31:0] d;
    logic [31:0] exp_rd;
    logic        exp_v;
    logic        exp_e;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input logic w, input logic r, input logic [2:0] f,
                              input logic [31:0] a, input logic [31:0] d,
                              input logic [31:0] xrd, input logic xv, input logic xe);
    vec_t t;
    t.w = w; t.r = r; t.f = f; t.a = a; t.d = d;
    t.exp_rd = xrd; t.exp_v = xv; t.exp_e = xe;
    return t;
  endfunction

  initial begin
    model_reset();

    // Directed vectors, applied after the clear-sequence load (rd = 0).
    tbl.push_back(mk(1'b1, 1'b0, 3'b010, 32'd500, 32'd2000,       32'd0,          1'b0, 1'b0));
    tbl.push_back(mk(1'b0, 1'b1, 3'b010, 32'd500, 32'd0,          32'd2000,       1'b1, 1'b0));
    tbl.push_back(mk(1'b0, 1'b1, 3'b010, 32'd564, 32'd0,          32'd2000,       1'b1, 1'b0));
    tbl.push_back(mk(1'b1, 1'b0, 3'b010, 32'd100, 32'h0000_0000,  32'd2000,       1'b0, 1'b0));
    tbl.push_back(mk(1'b1, 1'b0, 3'b000, 32'd101, 32'h0000_00FF,  32'd2000,       1'b0, 1'b0));
    tbl.push_back(mk(1'b1, 1'b0, 3'b001, 32'd102, 32'h0000_8001,  32'd2000,       1'b0, 1'b0));
    tbl.push_back(mk(1'b0, 1'b1, 3'b010, 32'd100, 32'd0,          32'h8001_FF00,  1'b1, 1'b0));
    tbl.push_back(mk(1'b0, 1'b1, 3'b000, 32'd101, 32'd0,          32'hFFFF_FFFF,  1'b1, 1'b0));
    tbl.push_back(mk(1'b0, 1'b1, 3'b100, 32'd101, 32'd0,          32'h0000_00FF,  1'b1, 1'b0));
    tbl.push_back(mk(1'b0, 1'b1, 3'b001, 32'd102, 32'd0,          32'hFFFF_8001,  1'b1, 1'b0));
    tbl.push_back(mk(1'b0, 1'b1, 3'b101, 32'd102, 32'd0,          32'h0000_8001,  1'b1, 1'b0));
    tbl.push_back(mk(1'b1, 1'b0, 3'b010, 32'd102, 32'hDEAD_BEEF,  32'h0000_8001,  1'b0, 1'b1));
    tbl.push_back(mk(1'b1, 1'b0, 3'b001, 32'd103, 32'h0000_1234,  32'h0000_8001,  1'b0, 1'b1));
    tbl.push_back(mk(1'b0, 1'b1, 3'b010, 32'd101, 32'd0,          32'h0000_8001,  1'b0, 1'b1));
    tbl.push_back(mk(1'b0, 1'b1, 3'b011, 32'd100, 32'd0,          32'h0000_8001,  1'b0, 1'b1));
    tbl.push_back(mk(1'b0, 1'b1, 3'b010, 32'd100, 32'd0,          32'h8001_FF00,  1'b1, 1'b0));
    tbl.push_back(mk(1'b1, 1'b1, 3'b010, 32'd8,   32'd7,          32'h8001_FF00,  1'b0, 1'b0));
    tbl.push_back(mk(1'b0, 1'b1, 3'b010, 32'd8,   32'd0,          32'd7,          1'b1, 1'b0));
    tbl.push_back(mk(1'b1, 1'b0, 3'b100, 32'd8,   32'd99,         32'd7,          1'b0, 1'b1));
    tbl.push_back(mk(1'b0, 1'b1, 3'b110, 32'd8,   32'd0,          32'd7,          1'b0, 1'b1));
    tbl.push_back(mk(1'b0, 1'b1, 3'b010, 32'd8,   32'd0,          32'd7,          1'b1, 1'b0));
    tbl.push_back(mk(1'b1, 1'b1, 3'b010, 32'd9,   32'd1,          32'd7,          1'b0, 1'b1));

    // Reset values.
    #12;
    check("reset_rd", rd, 32'h0);
    check("reset_rd_valid", {31'b0, rd_valid}, 32'h0);
    check("reset_ready", {31'b0, ready}, 32'h0);
    check("reset_err", {31'b0, err}, 32'h0);

    // Clear sequence. The bench pushes a store and loads into INIT.
    // They must have no effect.
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int e = 1; e <= DEPTH; e++) begin
      wr = 1'b1; re = e[0]; funct3 = 3'b010; rs = 32'd4; wd = 32'd5;
      @(posedge clk); #1;
      check($sformatf("init_ready_e%0d", e), {31'b0, ready}, {31'b0, (e == DEPTH)});
      check("init_rd_valid", {31'b0, rd_valid}, 32'h0);
      check("init_err", {31'b0, err}, 32'h0);
    end
    wr = 1'b0; re = 1'b0;
    op(1'b0, 1'b1, 3'b010, 32'd4, 32'd0, 1'b0);
    check("clear_lw4_rd", rd, 32'h0);
    check("clear_lw4_valid", {31'b0, rd_valid}, 32'h1);

    // Directed table.
    foreach (tbl[i]) begin
      op(tbl[i].w, tbl[i].r, tbl[i].f, tbl[i].a, tbl[i].d, 1'b0);
      check($sformatf("vec%0d_rd", i), rd, tbl[i].exp_rd);
      check($sformatf("vec%0d_rd_valid", i), {31'b0, rd_valid}, {31'b0, tbl[i].exp_v});
      check($sformatf("vec%0d_err", i), {31'b0, err}, {31'b0, tbl[i].exp_e});
    end

    // Random traffic against the model.
    for (int k = 0; k < 400; k++) begin
      logic [31:0] a;
      a = $urandom_range(0, 255);
      if ($urandom_range(0, 3) == 0) a = a | ($urandom << 8);
      op(($urandom_range(0, 2) == 0), $urandom_range(0, 1) == 1,
         3'($urandom_range(0, 7)), a, $urandom, 1'b1);
    end

    // Reset in the middle of a load: the outputs clear at once.
    op(1'b1, 1'b0, 3'b010, 32'd100, 32'hA5A5_1234, 1'b1);
    op(1'b0, 1'b1, 3'b010, 32'd100, 32'd0, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_rd", rd, 32'h0);
    check("async_rst_rd_valid", {31'b0, rd_valid}, 32'h0);
    check("async_rst_ready", {31'b0, ready}, 32'h0);
    check("async_rst_err", {31'b0, err}, 32'h0);
    model_reset();
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int e = 1; e <= 5; e++) begin
      @(posedge clk); #1;
      check("midinit_ready", {31'b0, ready}, 32'h0);
    end

    // Reset again in the middle of the clear: the clear restarts from word 0.
    #2 rst_n = 1'b0;
    #1 check("midinit_rst_ready", {31'b0, ready}, 32'h0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int e = 1; e <= DEPTH; e++) begin
      @(posedge clk); #1;
      check($sformatf("reclear_ready_e%0d", e), {31'b0, ready}, {31'b0, (e == DEPTH)});
    end
    op(1'b0, 1'b1, 3'b010, 32'd100, 32'd0, 1'b1);
    check("reclear_lw100", rd, 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
